pipe_controller: RTL and testbench
==================================

# pipe_controller

Pipelined control unit for the 19-bit-instruction processor. Decodes the instruction in ID and carries its control bundle through EX, MEM and WB registers. Detects load-use and flag hazards, generates stall, flush and PC-select. Tracks JSB/RET nesting against a bounded hardware return stack and raises sticky overflow/underflow flags.

## Interface
Parameters:
- STACK_DEPTH, 8, maximum JSB nesting held by the return stack; counter width is clog2(STACK_DEPTH+1).
- LOAD_USE_STALL, 1, 1 inserts a bubble on load-use; 0 means memory data is forwarded externally and no stall is raised.
- FLAG_STALL, 1, 1 stalls a branch while a flag writer is in EX; 0 means flags are forwarded externally.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the clk rising edge.
- instr_id  in  19  IF/ID instruction register contents.
- C, Z  in  1  committed carry/zero flags.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  load NOP (all zero) into IF/ID next edge.
- pc_mux  out  2  00 PC+1, 01 branch target, 10 JMP/JSB target, 11 return address.
- push, pop  out  1  return-stack strobes.
- id_reg_B_mux  out  1  register-file B read select (1 for memory class).
- ex_alu_op  out  3  ALU operation for EX.
- ex_alu_use_carry, ex_alu_B_mux, ex_select_c, ex_select_z, ex_write_c, ex_write_z  out  1 each  EX-stage controls.
- mem_write  out  1  data-memory write in MEM.
- wb_reg_write  out  1  register-file write in WB.
- wb_reg_write_mux  out  2  00 ALU, 01 shifter, 10 memory.
- wb_rd  out  3  WB destination register.
- stack_depth  out  clog2(STACK_DEPTH+1)  current nesting.
- stack_overflow, stack_underflow  out  1  sticky error flags.

## Operation
- Fields: class [18:16], sub [15:14], Rd [13:11], Rs [10:8], Rt [7:5].
- Class 0?? arithmetic (1?? = immediate): alu_op=[16:14], use_carry=[14], alu_B_mux=[17], write_c=write_z=1, select_c/z=0, reg_write, mux 00. Reads Rs, plus Rt if register form.
- Class 100 memory: [14]=1 STM (mem_write, reads Rd and Rs); [14]=0 LDM (reg_write, mux 10, reads Rs); alu_B_mux=1, alu_op=000.
- Class 110 shift: reg_write, mux 01, select_c/z=1, write_c/z=1, alu_op=000; reads Rs.
- Class 101 branch: [15]=0 tests Z, [15]=1 tests C; [14]=1 inverts the test. A taken branch gives pc_mux=01.
- [18:14]=11100 JMP; 11101 JSB, which also asserts push; [18:13]=111100 RET, which asserts pop and gives pc_mux=11.
- All other encodings are NOP (zero bundle).
- Load-use: EX holds an LDM whose Rd equals a register read by ID, and LOAD_USE_STALL=1 → stall=1.
- Flag hazard: ID holds a branch, EX has write_c|write_z, and FLAG_STALL=1 → stall=1.
- While stall=1:
  - pc_mux=00, flush=0, push=pop=0.
  - The EX bundle loads all zero (bubble); MEM and WB advance normally.
- Control transfer (pc_mux≠00, not stalled) → flush=1 for that cycle.
- JSB with stack_depth==STACK_DEPTH: push=0, pc_mux=00, flush=0, stack_overflow←1.
- RET with stack_depth==0: pop=0, pc_mux=00, flush=0, stack_underflow←1.
- stack_depth increments on an effective push and decrements on an effective pop. It never wraps.

## Timing
- Reset (reset==0 at an edge): all EX/MEM/WB bundles, stack_depth, stack_overflow and stack_underflow go to 0.
  - Combinational outputs then follow instr_id.
  - With instr_id=0, every output is 0.
- ID outputs (stall, flush, pc_mux, push, pop, id_reg_B_mux) are combinational in the same cycle as instr_id.
- ex_* is valid 1 cycle after ID, mem_write after 2 cycles, wb_* after 3 cycles.
- Load-use stall: exactly 1 cycle. The next cycle EX holds the bubble and the hazard clears.
- Flag stall: exactly 1 cycle.
- Taken branch/JMP/JSB/RET costs 1 flushed slot.
- Priority: reset > stall > stack error > control transfer.
- A stalled JSB/RET never changes stack_depth.
- The sticky flags clear only on reset.

## Test plan
- ADD (instr 0000001100101000000) then LDM r3, then ADD reading r3 → stall=1 for one cycle; ex_* all zero the next cycle; wb_reg_write pulses 3 cycles after each instruction.
- LOAD_USE_STALL=0, same LDM/use sequence → stall never asserts.
- Arithmetic followed by BZ with Z=1 → first a stall cycle with pc_mux=00, then pc_mux=01 and flush=1. With Z=0 → pc_mux=00 and no flush.
- STACK_DEPTH=2: JSB, JSB, JSB → depth 1, 2, 2; third JSB gives push=0 and pc_mux=00, then stack_overflow=1.
- RET at depth 0 → pop=0, pc_mux=00, stack_underflow=1. A later JSB/RET pair gives depth 1 then 0, with the flag still 1.
- reset low for one edge mid-stall with depth 3 → depth 0, flags 0, all EX/MEM/WB outputs 0 the next cycle.

Source files
------------

// File: rtl/pipe_controller.sv
// Pipelined control unit: ID decode, hazard/stall, PC select, return-stack depth.
// Ports: clk, reset (sync active-low), instr_id, C/Z flags in; ID, EX, MEM, WB controls out.
module pipe_controller #(
    parameter int STACK_DEPTH    = 8,
    parameter int LOAD_USE_STALL = 1,
    parameter int FLAG_STALL     = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [18:0]                        instr_id,
    input  logic                               C,
    input  logic                               Z,
    output logic                               stall,
    output logic                               flush,
    output logic [1:0]                         pc_mux,
    output logic                               push,
    output logic                               pop,
    output logic                               id_reg_B_mux,
    output logic [2:0]                         ex_alu_op,
    output logic                               ex_alu_use_carry,
    output logic                               ex_alu_B_mux,
    output logic                               ex_select_c,
    output logic                               ex_select_z,
    output logic                               ex_write_c,
    output logic                               ex_write_z,
    output logic                               mem_write,
    output logic                               wb_reg_write,
    output logic [1:0]                         wb_reg_write_mux,
    output logic [2:0]                         wb_rd,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    typedef struct packed {
        logic [2:0] alu_op;
        logic       use_carry;
        logic       b_mux;
        logic       sel_c;
        logic       sel_z;
        logic       wr_c;
        logic       wr_z;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_mux;
        logic [2:0] rd;
        logic       is_load;
    } ex_t;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_mux;
        logic [2:0] rd;
    } mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_mux;
        logic [2:0] rd;
    } wb_t;

    logic [2:0] cls;
    logic [1:0] sub;
    logic [2:0] f_rd;
    logic [2:0] f_rs;
    logic [2:0] f_rt;
    logic       unused_low;

    assign cls        = instr_id[18:16];
    assign sub        = instr_id[15:14];
    assign f_rd       = instr_id[13:11];
    assign f_rs       = instr_id[10:8];
    assign f_rt       = instr_id[7:5];
    assign unused_low = ^instr_id[4:0];

    ex_t            dec;
    logic           use_rd;
    logic           use_rs;
    logic           use_rt;
    logic           is_br;
    logic           is_jmp;
    logic           is_jsb;
    logic           is_ret;

    ex_t            ex_d, ex_q;
    mem_t           mem_d, mem_q;
    wb_t            wb_d, wb_q;
    logic [DW-1:0]  depth_d, depth_q;
    logic           ovf_d, ovf_q;
    logic           unf_d, unf_q;

    logic           load_use;
    logic           flag_haz;
    logic           br_taken;

    // Instruction decode into the EX control bundle plus register-read usage.
    always_comb begin
        dec    = '0;
        use_rd = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_br  = 1'b0;
        is_jmp = 1'b0;
        is_jsb = 1'b0;
        is_ret = 1'b0;
        unique case (1'b1)
            !cls[2]: begin
                dec.alu_op    = instr_id[16:14];
                dec.use_carry = instr_id[14];
                dec.b_mux     = instr_id[17];
                dec.wr_c      = 1'b1;
                dec.wr_z      = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = f_rd;
                use_rs        = 1'b1;
                use_rt        = !instr_id[17];
            end
            cls == 3'b100: begin
                dec.b_mux = 1'b1;
                dec.rd    = f_rd;
                use_rs    = 1'b1;
                if (instr_id[14]) begin
                    dec.mem_write = 1'b1;
                    use_rd        = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.wb_mux    = 2'b10;
                    dec.is_load   = 1'b1;
                end
            end
            cls == 3'b110: begin
                dec.sel_c     = 1'b1;
                dec.sel_z     = 1'b1;
                dec.wr_c      = 1'b1;
                dec.wr_z      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_mux    = 2'b01;
                dec.rd        = f_rd;
                use_rs        = 1'b1;
            end
            cls == 3'b101: is_br = 1'b1;
            cls == 3'b111: begin
                is_jmp = (sub == 2'b00);
                is_jsb = (sub == 2'b01);
                is_ret = (sub == 2'b10) && !instr_id[13];
            end
            default: ;
        endcase
    end

    always_comb begin
        load_use = (LOAD_USE_STALL != 0) && ex_q.is_load &&
                   ((use_rs && (f_rs == ex_q.rd)) ||
                    (use_rt && (f_rt == ex_q.rd)) ||
                    (use_rd && (f_rd == ex_q.rd)));
        flag_haz = (FLAG_STALL != 0) && is_br && (ex_q.wr_c || ex_q.wr_z);
        // [15] picks the flag, [14] inverts the sense
        br_taken = (instr_id[15] ? C : Z) ^ instr_id[14];
    end

    // PC select and return-stack bookkeeping; a stall suppresses all of it.
    always_comb begin
        pc_mux  = 2'b00;
        push    = 1'b0;
        pop     = 1'b0;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stall   = load_use || flag_haz;
        if (!stall) begin
            if (is_br && br_taken) begin
                pc_mux = 2'b01;
            end
            if (is_jmp) begin
                pc_mux = 2'b10;
            end
            if (is_jsb) begin
                if (depth_q == DEPTH_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pc_mux  = 2'b10;
                    push    = 1'b1;
                    depth_d = depth_q + DEPTH_ONE;
                end
            end
            if (is_ret) begin
                if (depth_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    pc_mux  = 2'b11;
                    pop     = 1'b1;
                    depth_d = depth_q - DEPTH_ONE;
                end
            end
        end
        flush = (pc_mux != 2'b00);
    end

    always_comb begin
        ex_d  = stall ? '0 : dec;
        mem_d = '{mem_write: ex_q.mem_write, reg_write: ex_q.reg_write,
                  wb_mux: ex_q.wb_mux, rd: ex_q.rd};
        wb_d  = '{reg_write: mem_q.reg_write, wb_mux: mem_q.wb_mux,
                  rd: mem_q.rd};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign id_reg_B_mux     = (cls == 3'b100);
    assign ex_alu_op        = ex_q.alu_op;
    assign ex_alu_use_carry = ex_q.use_carry;
    assign ex_alu_B_mux     = ex_q.b_mux;
    assign ex_select_c      = ex_q.sel_c;
    assign ex_select_z      = ex_q.sel_z;
    assign ex_write_c       = ex_q.wr_c;
    assign ex_write_z       = ex_q.wr_z;
    assign mem_write        = mem_q.mem_write;
    assign wb_reg_write     = wb_q.reg_write;
    assign wb_reg_write_mux = wb_q.wb_mux;
    assign wb_rd            = wb_q.rd;
    assign stack_depth      = depth_q;
    assign stack_overflow   = ovf_q;
    assign stack_underflow  = unf_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: vector table with pipeline scoreboard plus
// hand-written hazard, stack-limit and reset sequences.
module tb_pipe_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [18:0] instr = '0;
    logic        cc = 1'b0;
    logic        zz = 1'b0;

    always #5 clk = ~clk;

    // DUT A: default parameters
    logic a_stall, a_flush, a_push, a_pop, a_bmux;
    logic [1:0] a_pc;
    logic [2:0] a_alu_op;
    logic a_uc, a_bm, a_sc, a_sz, a_wc, a_wz, a_mw, a_rw;
    logic [1:0] a_mux;
    logic [2:0] a_rd;
    logic [3:0] a_depth;
    logic a_ovf, a_unf;

    pipe_controller u_a (
        .clk(clk), .reset(reset), .instr_id(instr), .C(cc), .Z(zz),
        .stall(a_stall), .flush(a_flush), .pc_mux(a_pc),
        .push(a_push), .pop(a_pop), .id_reg_B_mux(a_bmux),
        .ex_alu_op(a_alu_op), .ex_alu_use_carry(a_uc), .ex_alu_B_mux(a_bm),
        .ex_select_c(a_sc), .ex_select_z(a_sz),
        .ex_write_c(a_wc), .ex_write_z(a_wz),
        .mem_write(a_mw), .wb_reg_write(a_rw),
        .wb_reg_write_mux(a_mux), .wb_rd(a_rd),
        .stack_depth(a_depth), .stack_overflow(a_ovf),
        .stack_underflow(a_unf)
    );

    // DUT B: load data forwarded externally, no load-use stall
    logic b_stall, b_flush, b_push, b_pop, b_bmux;
    logic [1:0] b_pc;
    logic [2:0] b_alu_op;
    logic b_uc, b_bm, b_sc, b_sz, b_wc, b_wz, b_mw, b_rw;
    logic [1:0] b_mux;
    logic [2:0] b_rd;
    logic [3:0] b_depth;
    logic b_ovf, b_unf;

    pipe_controller #(.LOAD_USE_STALL(0)) u_b (
        .clk(clk), .reset(reset), .instr_id(instr), .C(cc), .Z(zz),
        .stall(b_stall), .flush(b_flush), .pc_mux(b_pc),
        .push(b_push), .pop(b_pop), .id_reg_B_mux(b_bmux),
        .ex_alu_op(b_alu_op), .ex_alu_use_carry(b_uc), .ex_alu_B_mux(b_bm),
        .ex_select_c(b_sc), .ex_select_z(b_sz),
        .ex_write_c(b_wc), .ex_write_z(b_wz),
        .mem_write(b_mw), .wb_reg_write(b_rw),
        .wb_reg_write_mux(b_mux), .wb_rd(b_rd),
        .stack_depth(b_depth), .stack_overflow(b_ovf),
        .stack_underflow(b_unf)
    );

    // DUT C: two-entry return stack
    logic c_stall, c_flush, c_push, c_pop, c_bmux;
    logic [1:0] c_pc;
    logic [2:0] c_alu_op;
    logic c_uc, c_bm, c_sc, c_sz, c_wc, c_wz, c_mw, c_rw;
    logic [1:0] c_mux;
    logic [2:0] c_rd;
    logic [1:0] c_depth;
    logic c_ovf, c_unf;

    pipe_controller #(.STACK_DEPTH(2)) u_c (
        .clk(clk), .reset(reset), .instr_id(instr), .C(cc), .Z(zz),
        .stall(c_stall), .flush(c_flush), .pc_mux(c_pc),
        .push(c_push), .pop(c_pop), .id_reg_B_mux(c_bmux),
        .ex_alu_op(c_alu_op), .ex_alu_use_carry(c_uc), .ex_alu_B_mux(c_bm),
        .ex_select_c(c_sc), .ex_select_z(c_sz),
        .ex_write_c(c_wc), .ex_write_z(c_wz),
        .mem_write(c_mw), .wb_reg_write(c_rw),
        .wb_reg_write_mux(c_mux), .wb_rd(c_rd),
        .stack_depth(c_depth), .stack_overflow(c_ovf),
        .stack_underflow(c_unf)
    );

    typedef struct packed {
        logic [2:0] alu_op;
        logic       uc, bm, sc, sz, wc, wz, mw, rw;
        logic [1:0] mux;
        logic [2:0] rd;
    } bun_t;

    typedef struct {
        logic [18:0] instr;
        logic        c, z;
        logic [6:0]  id_exp;
        bun_t        bun;
        logic [3:0]  depth;
    } vec_t;

    int   ncmp = 0;
    int   nfail = 0;
    vec_t vt[$];
    bun_t sbq[$];

    logic [6:0] a_id;
    logic [8:0] a_ex;
    logic [5:0] a_wb;
    assign a_id = {a_stall, a_flush, a_pc, a_push, a_pop, a_bmux};
    assign a_ex = {a_alu_op, a_uc, a_bm, a_sc, a_sz, a_wc, a_wz};
    assign a_wb = {a_rw, a_mux, a_rd};

    function automatic logic [18:0] enc(input logic [2:0] cl,
        input logic [1:0] sb, input logic [2:0] rd, rs, rt);
        return {cl, sb, rd, rs, rt, 5'b0};
    endfunction

    function automatic bun_t arith(input logic [2:0] op,
        input logic uc, bm, input logic [2:0] rd);
        bun_t b = '0;
        b.alu_op = op; b.uc = uc; b.bm = bm;
        b.wc = 1'b1; b.wz = 1'b1; b.rw = 1'b1; b.rd = rd;
        return b;
    endfunction

    function automatic bun_t ldm(input logic [2:0] rd);
        bun_t b = '0;
        b.bm = 1'b1; b.rw = 1'b1; b.mux = 2'b10; b.rd = rd;
        return b;
    endfunction

    function automatic bun_t stm(input logic [2:0] rd);
        bun_t b = '0;
        b.bm = 1'b1; b.mw = 1'b1; b.rd = rd;
        return b;
    endfunction

    function automatic bun_t shf(input logic [2:0] rd);
        bun_t b = '0;
        b.sc = 1'b1; b.sz = 1'b1; b.wc = 1'b1; b.wz = 1'b1;
        b.rw = 1'b1; b.mux = 2'b01; b.rd = rd;
        return b;
    endfunction

    task automatic add_vec(input logic [18:0] i, input logic c, z,
        input logic [6:0] id, input bun_t b, input logic [3:0] d);
        vec_t v;
        v.instr = i; v.c = c; v.z = z; v.id_exp = id; v.bun = b; v.depth = d;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [18:0] i);
        @(negedge clk);
        instr = i;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        instr = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [18:0] JSB = 19'b11101_000_000_000_00000;
    localparam logic [18:0] RET = 19'b11110_000_000_000_00000;

    initial begin
        bun_t e;
        logic [18:0] add_r5;
        logic [18:0] ldm_r3;
        ldm_r3 = enc(3'b100, 2'b00, 3'd3, 3'd1, 3'd0);
        add_r5 = enc(3'b000, 2'b00, 3'd5, 3'd3, 3'd2);

        // ID outputs: {stall, flush, pc_mux, push, pop, id_reg_B_mux}
        add_vec(enc(3'b000, 2'b00, 3'd3, 3'd1, 3'd2), 0, 0, 7'b0000000, arith(3'b000, 0, 0, 3'd3), 4'd0);
        add_vec(ldm_r3, 0, 0, 7'b0000001, ldm(3'd3), 4'd0);
        add_vec(add_r5, 0, 0, 7'b1000000, arith(3'b000, 0, 0, 3'd5), 4'd0);
        add_vec(add_r5, 0, 0, 7'b0000000, arith(3'b000, 0, 0, 3'd5), 4'd0);
        add_vec(enc(3'b011, 2'b01, 3'd6, 3'd5, 3'd0), 0, 0, 7'b0000000, arith(3'b101, 1, 1, 3'd6), 4'd0);
        add_vec(enc(3'b100, 2'b01, 3'd2, 3'd6, 3'd0), 0, 0, 7'b0000001, stm(3'd2), 4'd0);
        add_vec(enc(3'b100, 2'b00, 3'd1, 3'd2, 3'd0), 0, 0, 7'b0000001, ldm(3'd1), 4'd0);
        add_vec(enc(3'b100, 2'b01, 3'd1, 3'd4, 3'd0), 0, 0, 7'b1000001, stm(3'd1), 4'd0);
        add_vec(enc(3'b100, 2'b01, 3'd1, 3'd4, 3'd0), 0, 0, 7'b0000001, stm(3'd1), 4'd0);
        add_vec(enc(3'b110, 2'b00, 3'd7, 3'd1, 3'd0), 0, 0, 7'b0000000, shf(3'd7), 4'd0);
        add_vec(enc(3'b101, 2'b00, 3'd0, 3'd0, 3'd0), 0, 1, 7'b1000000, '0, 4'd0);
        add_vec(enc(3'b101, 2'b00, 3'd0, 3'd0, 3'd0), 0, 1, 7'b0101000, '0, 4'd0);
        add_vec(19'd0, 0, 1, 7'b0000000, arith(3'b000, 0, 0, 3'd0), 4'd0);
        add_vec(enc(3'b101, 2'b01, 3'd0, 3'd0, 3'd0), 0, 1, 7'b1000000, '0, 4'd0);
        add_vec(enc(3'b101, 2'b01, 3'd0, 3'd0, 3'd0), 0, 1, 7'b0000000, '0, 4'd0);
        add_vec(enc(3'b101, 2'b10, 3'd0, 3'd0, 3'd0), 1, 0, 7'b0101000, '0, 4'd0);
        add_vec(enc(3'b101, 2'b11, 3'd0, 3'd0, 3'd0), 1, 0, 7'b0000000, '0, 4'd0);
        add_vec(enc(3'b111, 2'b00, 3'd0, 3'd0, 3'd0), 0, 0, 7'b0110000, '0, 4'd0);
        add_vec(JSB, 0, 0, 7'b0110100, '0, 4'd1);
        add_vec(RET, 0, 0, 7'b0111010, '0, 4'd0);
        add_vec(RET, 0, 0, 7'b0000000, '0, 4'd0);
        for (int k = 0; k < 3; k++)
            add_vec(enc(3'b111, 2'b11, 3'd7, 3'd7, 3'd7), 0, 0, 7'b0000000, '0, 4'd0);

        // Reset state with instr_id = 0
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id", 32'(a_id), 32'd0);
        chk("rst_ex", 32'(a_ex), 32'd0);
        chk("rst_mem", 32'(a_mw), 32'd0);
        chk("rst_wb", 32'(a_wb), 32'd0);
        chk("rst_stk", {a_depth, a_ovf, a_unf}, 32'd0);
        reset = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            instr = vt[i].instr;
            cc = vt[i].c;
            zz = vt[i].z;
            #1;
            chk($sformatf("id[%0d]", i), 32'(a_id), 32'(vt[i].id_exp));
            step();
            sbq.push_back(vt[i].id_exp[6] ? bun_t'('0) : vt[i].bun);
            e = sbq[$];
            chk($sformatf("ex[%0d]", i), 32'(a_ex),
                32'({e.alu_op, e.uc, e.bm, e.sc, e.sz, e.wc, e.wz}));
            if (sbq.size() >= 2) begin
                e = sbq[sbq.size() - 2];
                chk($sformatf("mem[%0d]", i), 32'(a_mw), 32'(e.mw));
            end
            if (sbq.size() >= 3) begin
                e = sbq.pop_front();
                chk($sformatf("wb[%0d]", i), 32'(a_wb),
                    32'({e.rw, e.mux, e.rd}));
            end
            chk($sformatf("depth[%0d]", i), 32'(a_depth), 32'(vt[i].depth));
        end
        cc = 1'b0;
        zz = 1'b0;

        // Underflow is sticky across a later JSB/RET pair
        chk("unf_set", 32'(a_unf), 32'd1);
        put(JSB);
        step();
        chk("unf_jsb_depth", 32'(a_depth), 32'd1);
        put(RET);
        chk("unf_ret_id", 32'(a_id), 32'b0111010);
        step();
        chk("unf_ret_depth", 32'(a_depth), 32'd0);
        chk("unf_sticky", 32'(a_unf), 32'd1);

        // Load-use with forwarding: no stall on B, stall on A
        do_reset();
        put(ldm_r3);
        step();
        put(add_r5);
        chk("fwd_b_stall", 32'(b_stall), 32'd0);
        chk("fwd_a_stall", 32'(a_stall), 32'd1);
        step();

        // Return-stack overflow on the two-deep DUT
        do_reset();
        put(JSB);
        chk("ovf_push1", 32'({c_push, c_pc}), 32'b110);
        step();
        chk("ovf_depth1", 32'(c_depth), 32'd1);
        put(JSB);
        step();
        chk("ovf_depth2", 32'(c_depth), 32'd2);
        put(JSB);
        chk("ovf_id", 32'({c_stall, c_flush, c_pc, c_push, c_pop}), 32'd0);
        chk("ovf_pre", 32'(c_ovf), 32'd0);
        step();
        chk("ovf_depth3", 32'(c_depth), 32'd2);
        chk("ovf_flag", 32'(c_ovf), 32'd1);

        // Reset mid-stall with depth 3 and underflow set
        do_reset();
        put(RET);
        step();
        chk("rs_unf", 32'(a_unf), 32'd1);
        for (int k = 0; k < 3; k++) begin
            put(JSB);
            step();
        end
        chk("rs_depth3", 32'(a_depth), 32'd3);
        put(ldm_r3);
        step();
        put(add_r5);
        chk("rs_stall", 32'(a_stall), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        instr = '0;
        #1;
        chk("rs_stk", {a_depth, a_ovf, a_unf}, 32'd0);
        chk("rs_ex", 32'(a_ex), 32'd0);
        chk("rs_mem_wb", 32'({a_mw, a_wb}), 32'd0);
        chk("rs_id", 32'(a_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
